// File: rtl/mdu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mdu_pkg : shared types and constants for the HI/LO divide controller |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
package mdu_pkg;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_DIV  = 3'd1,
        OP_DIVU = 3'd2,
        OP_MTHI = 3'd3,
        OP_MTLO = 3'd4
    } hilo_op_t;

    typedef logic [1:0] hilo_state_t;

    localparam hilo_state_t ST_IDLE  = 2'd0;
    localparam hilo_state_t ST_ISSUE = 2'd1;
    localparam hilo_state_t ST_WAIT  = 2'd2;
    localparam hilo_state_t ST_FIN   = 2'd3;

    // Cycles the divider holds div_done low after it loads an operation.
    localparam int DIV_LAT_SIGNED   = 34;
    localparam int DIV_LAT_UNSIGNED = 32;

    function automatic logic is_div(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hilo_div_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hilo_div_ctrl : EX-stage issue/commit control for the iterative      |
// |                 divider, owning the architectural HI/LO registers    |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
module hilo_div_ctrl
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic        flush,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_op,
    output logic        div_signed,
    output logic [31:0] div_dividend,
    output logic [31:0] div_divisor,
    input  logic [63:0] div_result,
    input  logic        div_done
);

    hilo_state_t state_q, state_d;
    logic        kill_q, kill_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        div_op_q, div_op_d;
    logic        div_signed_q, div_signed_d;
    logic [31:0] dividend_q, dividend_d;
    logic [31:0] divisor_q, divisor_d;
    logic        accept;

    assign accept = req_valid & ~flush;

    always_comb begin
        state_d      = state_q;
        kill_d       = kill_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        div_op_d     = 1'b0;
        div_signed_d = div_signed_q;
        dividend_d   = dividend_q;
        divisor_d    = divisor_q;
        stall        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept && is_div(req_op)) begin
                    stall        = 1'b1;
                    state_d      = ST_ISSUE;
                    div_op_d     = 1'b1;
                    div_signed_d = (req_op == OP_DIV);
                    dividend_d   = req_a;
                    divisor_d    = req_b;
                end else if (accept && req_op == OP_MTHI) begin
                    hi_d = req_a;
                end else if (accept && req_op == OP_MTLO) begin
                    lo_d = req_a;
                end
            end
            ST_ISSUE: begin
                // div_done is still high from idle here, so it is not looked at.
                stall   = 1'b1;
                state_d = ST_WAIT;
                if (flush) kill_d = 1'b1;
            end
            ST_WAIT: begin
                // The divider cannot abort; a killed op keeps stalling until it drains.
                stall = 1'b1;
                if (flush) kill_d = 1'b1;
                if (div_done) begin
                    if (kill_q || flush) begin
                        state_d = ST_IDLE;
                    end else begin
                        lo_d    = div_result[63:32];
                        hi_d    = div_result[31:0];
                        state_d = ST_FIN;
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_d == ST_IDLE) kill_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            kill_q       <= 1'b0;
            hi_q         <= '0;
            lo_q         <= '0;
            div_op_q     <= 1'b0;
            div_signed_q <= 1'b0;
            dividend_q   <= '0;
            divisor_q    <= '0;
        end else begin
            state_q      <= state_d;
            kill_q       <= kill_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            div_op_q     <= div_op_d;
            div_signed_q <= div_signed_d;
            dividend_q   <= dividend_d;
            divisor_q    <= divisor_d;
        end
    end

    assign hi           = hi_q;
    assign lo           = lo_q;
    assign div_op       = div_op_q;
    assign div_signed   = div_signed_q;
    assign div_dividend = dividend_q;
    assign div_divisor  = divisor_q;

endmodule
`default_nettype wire

// File: tb/tb_hilo_div_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_hilo_div_ctrl : directed self-checking bench with a divider model |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
module tb_hilo_div_ctrl;
    import mdu_pkg::*;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic [2:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        flush;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_op;
    logic        div_signed;
    logic [31:0] div_dividend;
    logic [31:0] div_divisor;
    logic [63:0] div_result;
    logic        div_done;

    int n_cmp = 0;
    int n_bad = 0;

    hilo_div_ctrl u_dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_op       (req_op),
        .req_a        (req_a),
        .req_b        (req_b),
        .flush        (flush),
        .stall        (stall),
        .hi           (hi),
        .lo           (lo),
        .div_op       (div_op),
        .div_signed   (div_signed),
        .div_dividend (div_dividend),
        .div_divisor  (div_divisor),
        .div_result   (div_result),
        .div_done     (div_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Divider model: busy for the fixed latency after a start pulse.
    logic [5:0]  m_cnt;
    logic [31:0] m_q;
    logic [31:0] m_r;

    always @(posedge clk) begin
        if (rst) begin
            m_cnt <= '0;
            m_q   <= '0;
            m_r   <= '0;
        end else if (div_op) begin
            m_cnt <= div_signed ? 6'(DIV_LAT_SIGNED) : 6'(DIV_LAT_UNSIGNED);
            if (div_divisor == 32'd0) begin
                m_q <= 32'hFFFF_FFFF;
                m_r <= div_dividend;
            end else if (div_signed) begin
                m_q <= 32'($signed(div_dividend) / $signed(div_divisor));
                m_r <= 32'($signed(div_dividend) % $signed(div_divisor));
            end else begin
                m_q <= div_dividend / div_divisor;
                m_r <= div_dividend % div_divisor;
            end
        end else if (m_cnt != 6'd0) begin
            m_cnt <= m_cnt - 6'd1;
        end
    end

    assign div_done   = (m_cnt == 6'd0);
    assign div_result = {m_q, m_r};

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    // Runs one divide from the current low clock phase. Index 1 is the accept
    // cycle; flush_at/mt_at/rst_at (0 = unused) inject events at that index.
    task automatic run_div(input string tag, input logic [2:0] op,
                           input logic [31:0] a, input logic [31:0] b,
                           input int exp_stall,
                           input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                           input int flush_at, input int mt_at, input int rst_at);
        int n;
        int pulses;
        bit dead;
        logic [31:0] lo_before;
        n = 0;
        pulses = 0;
        dead = 1'b0;
        lo_before = lo;
        while (n < 100) begin
            flush = (n + 1 == flush_at);
            rst   = (n + 1 == rst_at);
            if (flush || rst) dead = 1'b1;
            req_valid = ~dead;
            req_op = (n + 1 == mt_at) ? 3'(OP_MTLO) : op;
            req_a  = (n + 1 == mt_at) ? 32'hAAAA_5555 : a;
            req_b  = b;
            #1;
            if (!stall) break;
            n++;
            if (div_op) begin
                pulses++;
                chk({tag, ".div_signed"}, 64'(div_signed), 64'(op == OP_DIV));
            end
            if (mt_at != 0 && n == mt_at + 1)
                chk({tag, ".mtlo_in_wait"}, 64'(lo), 64'(lo_before));
            @(negedge clk);
        end
        if (n >= 100) chk({tag, ".timeout"}, 64'(n), 64'(exp_stall));
        flush = 1'b0;
        rst   = 1'b0;
        if (rst_at != 0) begin
            chk({tag, ".rst_hilo"}, {hi, lo}, 64'd0);
            chk({tag, ".rst_stall"}, 64'(stall), 64'd0);
            chk({tag, ".rst_divop"}, {62'd0, div_op, div_signed}, 64'd0);
            chk({tag, ".rst_operands"}, {div_dividend, div_divisor}, 64'd0);
        end else begin
            chk({tag, ".stall_cycles"}, 64'(n), 64'(exp_stall));
            chk({tag, ".div_op_pulses"}, 64'(pulses), 64'(flush_at != 0 ? 1 : 1));
            chk({tag, ".lo"}, 64'(lo), 64'(exp_lo));
            chk({tag, ".hi"}, 64'(hi), 64'(exp_hi));
            if (flush_at == 0) begin
                req_valid = 1'b0;
                req_op = 3'(OP_NOP);
                @(negedge clk);
                #1;
                chk({tag, ".idle_div_op"}, 64'(div_op), 64'd0);
            end
        end
        req_valid = 1'b0;
        req_op = 3'(OP_NOP);
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0;
        req_op = 3'(OP_NOP);
        req_a = '0;
        req_b = '0;
        flush = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset.hilo", {hi, lo}, 64'd0);
        chk("reset.stall", 64'(stall), 64'd0);
        chk("reset.div_op", 64'(div_op), 64'd0);

        // 100/7 unsigned: q=14 r=2, 35 stall cycles.
        run_div("divu_100_7", 3'(OP_DIVU), 32'd100, 32'd7, 35, 32'd14, 32'd2, 0, 0, 0);

        // -7/2 signed: q=-3 r=-1, 37 stall cycles, stray MTLO in WAIT ignored.
        run_div("div_m7_2", 3'(OP_DIV), 32'hFFFF_FFF9, 32'd2, 37,
                32'hFFFF_FFFD, 32'hFFFF_FFFF, 0, 10, 0);

        // Back-to-back MTHI/MTLO in IDLE, no stall.
        req_valid = 1'b1;
        req_op = 3'(OP_MTHI);
        req_a = 32'hDEAD_BEEF;
        #1;
        chk("mthi.stall", 64'(stall), 64'd0);
        @(negedge clk);
        req_op = 3'(OP_MTLO);
        req_a = 32'h1234_5678;
        #1;
        chk("mthi.hi", 64'(hi), 64'hDEAD_BEEF);
        chk("mtlo.stall", 64'(stall), 64'd0);
        @(negedge clk);
        req_valid = 1'b0;
        req_op = 3'(OP_NOP);
        #1;
        chk("mtlo.lo", 64'(lo), 64'h1234_5678);
        chk("mtlo.hi_kept", 64'(hi), 64'hDEAD_BEEF);

        // Flushed DIVU 50/5 in WAIT cycle 5: no commit, straight back to IDLE.
        run_div("divu_flush", 3'(OP_DIVU), 32'd50, 32'd5, 35,
                32'h1234_5678, 32'hDEAD_BEEF, 7, 0, 0);
        run_div("divu_9_3_a", 3'(OP_DIVU), 32'd9, 32'd3, 35, 32'd3, 32'd0, 0, 0, 0);

        // Reset at WAIT cycle 10 of DIV 1000/3, then a clean DIVU.
        run_div("div_rst", 3'(OP_DIV), 32'd1000, 32'd3, 0, 32'd0, 32'd0, 0, 0, 12);
        run_div("divu_9_3_b", 3'(OP_DIVU), 32'd9, 32'd3, 35, 32'd3, 32'd0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
